mod_counter: RTL and testbench

- Free-running modulo-N up-counter. Counts 0, 1, …, N-1, then wraps to 0.
- Used as a generic timebase and sequence index in datapath and control blocks.
- Adds a synchronous enable, a synchronous clear, and a terminal-count strobe, so parents can cascade counters or derive periodic ticks.

---
 rtl/mod_counter_pkg.sv | 23 ++
 rtl/mod_counter.sv | 67 ++++++
 tb/tb_mod_counter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mod_counter_pkg.sv
// Shared constants, control bundle and width helper for mod_counter and its parents.
package mod_counter_pkg;

  localparam int MOD_COUNTER_N_DEF     = 8;
  localparam int MOD_COUNTER_WIDTH_DEF = 4;

  // Per-edge control inputs, gathered so the next-state logic reads as one decision.
  typedef struct packed {
    logic clr;
    logic load;
    logic en;
  } cnt_ctrl_t;

  // Smallest WIDTH that can hold 0..n-1 (ceiling log2, never below 1).
  function automatic int mod_counter_min_width(input int n);
    int w;
    w = 31;
    for (int i = 31; i >= 1; i--)
      if ((64'd1 << i) >= longint'(n)) w = i;
    return w;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up-counter with enable, synchronous clear and terminal-count strobe.
// Define MOD_COUNTER_LOAD_EN to add a synchronous parallel load (load, load_val).
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int N     = MOD_COUNTER_N_DEF,
  parameter int WIDTH = MOD_COUNTER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
`ifdef MOD_COUNTER_LOAD_EN
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc
);

  if (N < 2) begin : g_bad_n
    $error("mod_counter: N must be at least 2");
  end
  if ((64'd1 << WIDTH) < longint'(N)) begin : g_bad_width
    $error("mod_counter: WIDTH too small for N");
  end

  // Every compare is against N-1 held in WIDTH bits, so N == 2**WIDTH never overflows.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(N - 1);

  cnt_ctrl_t        ctrl;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    ctrl.clr = clr;
    ctrl.en  = en;
`ifdef MOD_COUNTER_LOAD_EN
    ctrl.load = load;
`else
    ctrl.load = 1'b0;
`endif
  end

  always_comb begin
    nxt = out;
    if (ctrl.clr) begin
      nxt = '0;
    end else if (ctrl.load) begin
`ifdef MOD_COUNTER_LOAD_EN
      nxt = (load_val > LAST) ? '0 : load_val;
`else
      nxt = '0;
`endif
    end else if (ctrl.en) begin
      // >= also recovers a corrupted out-of-range state in one enabled edge.
      nxt = (out >= LAST) ? '0 : out + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out <= '0;
    else     out <= nxt;
  end

  assign tc = ctrl.en & ~ctrl.load & ~rst & (out == LAST);

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (N=8, WIDTH=4): vector table, corner sequences, random vs model.
module tb_mod_counter;
  localparam int N = 8;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b1;
  logic         clr = 1'b0;
  logic [W-1:0] out;
  logic         tc;
`ifdef MOD_COUNTER_LOAD_EN
  logic         load     = 1'b0;
  logic [W-1:0] load_val = '0;
`endif

  int total = 0;
  int bad   = 0;
  int cur   = 0;
  int pulses;

  mod_counter #(.N(N), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr),
`ifdef MOD_COUNTER_LOAD_EN
    .load(load), .load_val(load_val),
`endif
    .out(out), .tc(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic clr;
    logic exp_tc;
    int   exp_out;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: tc checked before the edge, out checked just after it.
  task automatic cyc(input logic e, input logic c, input logic etc, input int eout, input string name);
    en  = e;
    clr = c;
    #1;
    chk({name, ".tc"}, int'(tc), int'(etc));
    @(posedge clk);
    #1;
    chk({name, ".out"}, int'(out), eout);
  endtask

  // Enabled counting driven by plain modular arithmetic until cur reaches target.
  task automatic run_to(input int target, input string name);
    while (cur != target) begin
      logic t;
      t   = (cur == N - 1);
      cur = (cur + 1) % N;
      cyc(1'b1, 1'b0, t, cur, name);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 7; i++) vecs[i] = '{1'b1, 1'b0, 1'b0, i + 1};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 0};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 1};

    // Reset held with en high: out and tc must stay low across an edge.
    #2;
    chk("rst_pre.out", int'(out), 0);
    chk("rst_pre.tc", int'(tc), 0);
    #5;
    chk("rst_edge.out", int'(out), 0);
    chk("rst_edge.tc", int'(tc), 0);
    #3;
    rst = 1'b0;

    foreach (vecs[i]) cyc(vecs[i].en, vecs[i].clr, vecs[i].exp_tc, vecs[i].exp_out, $sformatf("vec%0d", i));
    cur = 1;

    // 20 enabled edges from 0: exactly two one-cycle tc pulses.
    run_to(0, "to0");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      logic t;
      t = (cur == N - 1);
      if (t) pulses++;
      cur = (cur + 1) % N;
      cyc(1'b1, 1'b0, t, cur, "run20");
    end
    chk("run20.pulses", pulses, 2);

    run_to(3, "to3");
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 3, "hold");
    cyc(1'b1, 1'b0, 1'b0, 4, "resume");
    cyc(1'b1, 1'b0, 1'b0, 5, "to5");
    cyc(1'b1, 1'b1, 1'b0, 0, "clr5");
    cur = 0;
    run_to(7, "to7");
    cyc(1'b1, 1'b1, 1'b1, 0, "clr7");
    cur = 0;

    // Asynchronous reset between edges at out == 6.
    run_to(6, "to6");
    #2 rst = 1'b1;
    #1;
    chk("async6.out", int'(out), 0);
    chk("async6.tc", int'(tc), 0);
    #4 rst = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1, "restart");
    cur = 1;

    // Reset at out == 7 with en high must drop tc in the same instant.
    run_to(7, "to7b");
    #1;
    chk("pre_rst7.tc", int'(tc), 1);
    rst = 1'b1;
    #1;
    chk("async7.out", int'(out), 0);
    chk("async7.tc", int'(tc), 0);
    #4 rst = 1'b0;
    cur = 0;
    cyc(1'b0, 1'b0, 1'b0, 0, "idle");

`ifdef MOD_COUNTER_LOAD_EN
    en = 1'b1; load = 1'b1; load_val = 4'd6;
    @(posedge clk); #1;
    chk("load6.out", int'(out), 6);
    load = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 7, "load6+1");
    cyc(1'b1, 1'b0, 1'b1, 0, "load6+2");
    load = 1'b1; load_val = 4'd12;
    @(posedge clk); #1;
    chk("load12.out", int'(out), 0);
    load_val = 4'd7;
    @(posedge clk); #1;
    chk("load7.out", int'(out), 7);
    #1;
    chk("load7.tc_suppressed", int'(tc), 0);
    clr = 1'b1; load_val = 4'd5;
    @(posedge clk); #1;
    chk("clr_load.out", int'(out), 0);
    clr = 1'b0; load = 1'b0;
    cur = 0;
`endif

    // Random traffic against the arithmetic model.
    for (int i = 0; i < 400; i++) begin
      logic e, c, l, t;
      int   lv;
      e  = ($urandom_range(0, 9) < 7);
      c  = ($urandom_range(0, 19) == 0);
      l  = 1'b0;
      lv = 0;
`ifdef MOD_COUNTER_LOAD_EN
      l  = ($urandom_range(0, 14) == 0);
      lv = $urandom_range(0, 15);
      load = l; load_val = W'(lv);
`endif
      en = e; clr = c;
      #1;
      t = e && !l && (cur == N - 1);
      chk("rnd.tc", int'(tc), int'(t));
      if (c)      cur = 0;
      else if (l) cur = (lv < N) ? lv : 0;
      else if (e) cur = (cur + 1) % N;
      @(posedge clk); #1;
      chk("rnd.out", int'(out), cur);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
